instr_fetch: RTL and testbench

Stage-1 fetch unit of the 5-stage MIPS core. It owns the program counter and issues word reads to the instruction cache, whose read is synchronous with one-cycle latency. Returned words go into a small in-order fetch queue, which hands them to instruction decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and squash the in-flight read.

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one-cycle-latency I-cache reads and buffers
// returned words in a small in-order queue drained by decode via valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iCacheReadAddr,
    output logic        iCacheReadEn,
    input  logic [31:0] iCacheReadData,
    input  logic        redirectEn,
    input  logic [31:0] redirectPC,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrData,
    output logic [31:0] instrPC,
    output logic        alignErr
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          align_err_q, align_err_d;

    logic [31:0]   q_data_q [QDEPTH];
    logic [31:0]   q_pc_q   [QDEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;

    always_comb begin
        instrValid = !rst && !redirectEn && (count_q != '0);
        pop        = instrValid && instrReady;
        push       = inflight_q && !redirectEn && !rst;
        // Lookahead on pop lets issue continue at full rate when the queue is full but draining.
        occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue      = !rst && !redirectEn && (occupancy < QDEPTH_W);

        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        align_err_d = 1'b0;

        if (redirectEn) begin
            fetch_pc_d  = {redirectPC[31:2], 2'b00};
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            align_err_d = (redirectPC[1:0] != 2'b00);
        end else begin
            if (issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
        end
    end

    // Queue storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data_q[wr_ptr_q] <= iCacheReadData;
            q_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign iCacheReadAddr = fetch_pc_q;
    assign iCacheReadEn   = issue;
    assign instrData      = instrValid ? q_data_q[rd_ptr_q] : 32'h0;
    assign instrPC        = instrValid ? q_pc_q[rd_ptr_q]   : 32'h0;
    assign alignErr       = align_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, stall, redirects, PC wrap
// and mid-stream reset, against a one-cycle-latency cache model.
module tb_instr_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] iCacheReadAddr;
    logic        iCacheReadEn;
    logic [31:0] iCacheReadData;
    logic        redirectEn;
    logic [31:0] redirectPC;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrData;
    logic [31:0] instrPC;
    logic        alignErr;

    int n_cmp;
    int n_err;

    instr_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .iCacheReadAddr (iCacheReadAddr),
        .iCacheReadEn   (iCacheReadEn),
        .iCacheReadData (iCacheReadData),
        .redirectEn     (redirectEn),
        .redirectPC     (redirectPC),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instrData      (instrData),
        .instrPC        (instrPC),
        .alignErr       (alignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous cache: word = address ^ KEY, returned the cycle after the request.
    always @(posedge clk) begin
        if (iCacheReadEn) iCacheReadData <= iCacheReadAddr ^ KEY;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle: inputs change on the falling edge, outputs are checked 1ns later.
    task automatic step(input logic r, input logic rdy, input logic re, input logic [31:0] rpc);
        @(negedge clk);
        rst        = r;
        instrReady = rdy;
        redirectEn = re;
        redirectPC = rpc;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, instrValid}, {31'b0, v});
        chk({tag, ".pc"}, instrPC, v ? pc : 32'h0);
        chk({tag, ".data"}, instrData, v ? (pc ^ KEY) : 32'h0);
    endtask

    task automatic chk_fetch(input string tag, input logic en, input logic [31:0] addr);
        chk({tag, ".en"}, {31'b0, iCacheReadEn}, {31'b0, en});
        chk({tag, ".addr"}, iCacheReadAddr, addr);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; instrReady = 1'b1; redirectEn = 1'b0; redirectPC = 32'h0;

        // Reset held across one rising edge.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk_fetch("rst", 1'b0, 32'h0);
        chk_head("rst", 1'b0, 32'h0);
        chk("rst.alignErr", {31'b0, alignErr}, 32'h0);

        // C0..C1: RESET_PC then 4 issued, nothing valid yet.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_fetch("C0", 1'b1, 32'h0);
        chk_head("C0", 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_fetch("C1", 1'b1, 32'h4);
        chk_head("C1", 1'b0, 32'h0);

        // C2..C7: decode stalls; one word queued plus one in flight fills QDEPTH=2.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_head("C2", 1'b1, 32'h0);
        chk_fetch("C2", 1'b0, 32'h8);
        for (int c = 3; c <= 7; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            chk_head($sformatf("C%0d_stall", c), 1'b1, 32'h0);
            chk_fetch($sformatf("C%0d_stall", c), 1'b0, 32'h8);
        end

        // C8..C11: release; pop and issue resume in the same cycle, no gap or duplicate.
        for (int c = 8; c <= 11; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk_head($sformatf("C%0d_run", c), 1'b1, 32'(4 * (c - 8)));
            chk_fetch($sformatf("C%0d_run", c), 1'b1, 32'(4 * (c - 6)));
        end

        // C12: redirect to 0x100 with a queued word and a read in flight.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk_head("R1", 1'b0, 32'h0);
        chk("R1.en", {31'b0, iCacheReadEn}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_fetch("R1+1", 1'b1, 32'h100);
        chk_head("R1+1", 1'b0, 32'h0);
        chk("R1+1.alignErr", {31'b0, alignErr}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R1+2", 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R1+3", 1'b1, 32'h100);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R1+4", 1'b1, 32'h104);

        // Misaligned redirect: fetch from 0x204, alignErr pulses in R+1 only.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0206);
        chk_head("R2", 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("R2+1.alignErr", {31'b0, alignErr}, 32'h1);
        chk_fetch("R2+1", 1'b1, 32'h204);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("R2+2.alignErr", {31'b0, alignErr}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R2+3", 1'b1, 32'h204);

        // Redirect near the top of the address space: PC wraps to 0.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk_head("R3", 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_fetch("R3+1", 1'b1, 32'hFFFF_FFF8);
        chk("R3+1.alignErr", {31'b0, alignErr}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_fetch("R3+2", 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R3+3", 1'b1, 32'hFFFF_FFF8);
        chk_fetch("R3+3", 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R3+4", 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R3+5", 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("R3+6", 1'b1, 32'h4);

        // Reset coinciding with a would-be pop and a misaligned redirect: reset wins.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0302);
        chk_head("RST2", 1'b0, 32'h0);
        chk("RST2.en", {31'b0, iCacheReadEn}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("RST2+1.alignErr", {31'b0, alignErr}, 32'h0);
        chk_head("RST2+1", 1'b0, 32'h0);
        chk_fetch("RST2+1", 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("RST2+2", 1'b0, 32'h0);
        chk_fetch("RST2+2", 1'b1, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("RST2+3", 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_head("RST2+4", 1'b1, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
